// File: rtl/systolic_output_requant.sv
// Requantizes the systolic array's int8 result stream: per-lane bias, rounding shift, int8 saturation
// and optional ReLU, then buffers the beats in a show-ahead FIFO framed with sop/eop per tile.
module systolic_output_requant #(
  parameter int LANES          = 16,
  parameter int LANE_W         = 8,
  parameter int FIFO_DEPTH     = 4,
  parameter int BEATS_PER_TILE = 16
) (
  input  logic                      CLOCK,
  input  logic                      reset,
  input  logic                      flush,
  input  logic [7:0]                cfg_bias,
  input  logic [2:0]                cfg_shift,
  input  logic                      cfg_relu,
  input  logic [LANES*LANE_W-1:0]   in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [LANES*LANE_W-1:0]   out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_sop,
  output logic                      out_eop,
  output logic [31:0]               tile_count,
  output logic [31:0]               sat_count
);

  localparam int DATA_W = LANES * LANE_W;
  localparam int ACC_W  = LANE_W + 2;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BEAT_W = $clog2(BEATS_PER_TILE);
  localparam int CLIP_W = $clog2(LANES + 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS_PER_TILE - 1);
  localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(FIFO_DEPTH);

  // Returns {clipped, result} for one lane; the intermediate is two bits wider than a lane.
  function automatic logic [LANE_W:0] requant_lane(
    input logic [LANE_W-1:0] x,
    input logic [7:0]        bias,
    input logic [2:0]        shift,
    input logic              relu
  );
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] rnd;
    logic signed [ACC_W-1:0] shifted;
    logic signed [ACC_W-1:0] hi;
    logic signed [ACC_W-1:0] lo;
    logic [LANE_W-1:0]       res;
    logic                    clip;
    hi      = $signed({3'b000, {(LANE_W-1){1'b1}}});
    lo      = $signed({3'b111, {(LANE_W-1){1'b0}}});
    sum     = $signed({{2{x[LANE_W-1]}}, x}) + $signed({{(ACC_W-8){bias[7]}}, bias});
    rnd     = $signed({{(ACC_W-1){1'b0}}, 1'b1} << (shift - 3'd1));
    shifted = (shift != 3'd0) ? ((sum + rnd) >>> shift) : sum;
    if (shifted > hi) begin
      res  = hi[LANE_W-1:0];
      clip = 1'b1;
    end else if (shifted < lo) begin
      res  = lo[LANE_W-1:0];
      clip = 1'b1;
    end else begin
      res  = shifted[LANE_W-1:0];
      clip = 1'b0;
    end
    res = (relu && res[LANE_W-1]) ? '0 : res;
    return {clip, res};
  endfunction

  logic                    started_r;
  logic [BEAT_W-1:0]       in_beat_r;
  logic [7:0]              bias_r;
  logic [2:0]              shift_r;
  logic                    relu_r;
  logic                    pipe_valid_r;
  logic [DATA_W-1:0]       pipe_data_r;
  logic [31:0]             sat_count_r;
  logic [DATA_W-1:0]       mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_r;
  logic [PTR_W-1:0]        rd_ptr_r;
  logic [CNT_W-1:0]        fifo_count_r;
  logic [BEAT_W-1:0]       out_beat_r;
  logic [31:0]             tile_count_r;

  logic [7:0]              eff_bias_s;
  logic [2:0]              eff_shift_s;
  logic                    eff_relu_s;
  logic [LANE_W:0]         lane_s;
  logic [DATA_W-1:0]       beat_result_s;
  logic [CLIP_W-1:0]       clip_count_s;
  logic [32:0]             sat_sum_s;
  logic [CNT_W-1:0]        occupancy_s;
  logic                    accept_s;
  logic                    emit_s;
  logic                    push_s;

  // Beat 0 of a tile uses the live config; later beats reuse what beat 0 latched.
  always_comb begin
    eff_bias_s    = (in_beat_r == '0) ? cfg_bias  : bias_r;
    eff_shift_s   = (in_beat_r == '0) ? cfg_shift : shift_r;
    eff_relu_s    = (in_beat_r == '0) ? cfg_relu  : relu_r;
    lane_s        = '0;
    beat_result_s = '0;
    clip_count_s  = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_s = requant_lane(in_data[i*LANE_W +: LANE_W], eff_bias_s, eff_shift_s, eff_relu_s);
      beat_result_s[i*LANE_W +: LANE_W] = lane_s[LANE_W-1:0];
      clip_count_s = clip_count_s + CLIP_W'(lane_s[LANE_W]);
    end
    sat_sum_s = {1'b0, sat_count_r} + 33'(clip_count_s);
  end

  // One slot is always held back for the pipe stage, so the FIFO can never overflow.
  assign occupancy_s = fifo_count_r + CNT_W'(pipe_valid_r);
  assign in_ready    = started_r && !flush && (occupancy_s < DEPTH_CNT);
  assign accept_s    = in_valid && in_ready;
  assign out_valid   = (fifo_count_r != '0);
  assign emit_s      = out_valid && out_ready && !flush;
  assign push_s      = pipe_valid_r;
  assign out_data    = out_valid ? mem_r[rd_ptr_r] : '0;
  assign out_sop     = out_valid && (out_beat_r == '0);
  assign out_eop     = out_valid && (out_beat_r == LAST_BEAT);
  assign tile_count  = tile_count_r;
  assign sat_count   = sat_count_r;

  // Input side: config latch, input beat counter, arithmetic pipe stage and saturation counter.
  always_ff @(posedge CLOCK or posedge reset) begin
    if (reset) begin
      started_r    <= 1'b0;
      in_beat_r    <= '0;
      bias_r       <= 8'd0;
      shift_r      <= 3'd0;
      relu_r       <= 1'b0;
      pipe_valid_r <= 1'b0;
      pipe_data_r  <= '0;
      sat_count_r  <= 32'd0;
    end else begin
      started_r <= 1'b1;
      if (flush) begin
        in_beat_r    <= '0;
        pipe_valid_r <= 1'b0;
      end else begin
        pipe_valid_r <= accept_s;
        if (accept_s) begin
          pipe_data_r <= beat_result_s;
          bias_r      <= eff_bias_s;
          shift_r     <= eff_shift_s;
          relu_r      <= eff_relu_s;
          in_beat_r   <= (in_beat_r == LAST_BEAT) ? '0 : in_beat_r + 1'b1;
          sat_count_r <= sat_sum_s[32] ? 32'hFFFF_FFFF : sat_sum_s[31:0];
        end
      end
    end
  end

  // Output side: show-ahead FIFO, output beat framing and completed-tile counter.
  always_ff @(posedge CLOCK or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r     <= '0;
      rd_ptr_r     <= '0;
      fifo_count_r <= '0;
      out_beat_r   <= '0;
      tile_count_r <= 32'd0;
    end else if (flush) begin
      wr_ptr_r     <= '0;
      rd_ptr_r     <= '0;
      fifo_count_r <= '0;
      out_beat_r   <= '0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= pipe_data_r;
        wr_ptr_r        <= wr_ptr_r + 1'b1;
      end
      if (emit_s) begin
        rd_ptr_r   <= rd_ptr_r + 1'b1;
        out_beat_r <= (out_beat_r == LAST_BEAT) ? '0 : out_beat_r + 1'b1;
        if (out_beat_r == LAST_BEAT) begin
          tile_count_r <= tile_count_r + 32'd1;
        end
      end
      case ({push_s, emit_s})
        2'b10:   fifo_count_r <= fifo_count_r + 1'b1;
        2'b01:   fifo_count_r <= fifo_count_r - 1'b1;
        default: fifo_count_r <= fifo_count_r;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_output_requant.sv
// Directed bench for systolic_output_requant: a queue-based reference model checks every output beat,
// and literal expectations pin the model and the spec's worked examples.
module tb_systolic_output_requant;

  logic         CLOCK = 1'b0;
  logic         reset;
  logic         flush;
  logic [7:0]   cfg_bias;
  logic [2:0]   cfg_shift;
  logic         cfg_relu;
  logic [127:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_sop;
  logic         out_eop;
  logic [31:0]  tile_count;
  logic [31:0]  sat_count;

  systolic_output_requant dut (
    .CLOCK(CLOCK), .reset(reset), .flush(flush),
    .cfg_bias(cfg_bias), .cfg_shift(cfg_shift), .cfg_relu(cfg_relu),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_sop(out_sop), .out_eop(out_eop),
    .tile_count(tile_count), .sat_count(sat_count)
  );

  always #5 CLOCK = ~CLOCK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Plain-integer reference for one lane; bit 8 of the result flags a saturation.
  function automatic int model_lane(input int x, input int b, input int sh, input bit rl);
    int s, d, q, clip;
    s = x + b;
    if (sh > 0) begin
      d = 1 << sh;
      s = s + d / 2;
      q = s / d;
      if ((s % d) != 0 && s < 0) q = q - 1;
      s = q;
    end
    clip = 0;
    if (s > 127) begin s = 127; clip = 1; end
    if (s < -128) begin s = -128; clip = 1; end
    if (rl && s < 0) s = 0;
    return (clip * 256) + (s & 255);
  endfunction

  function automatic void model_beat(input logic [127:0] d, input int b, input int sh, input bit rl,
                                     output logic [127:0] r, output int nclip);
    int v;
    r = '0;
    nclip = 0;
    for (int i = 0; i < 16; i++) begin
      v = model_lane(int'($signed(d[127-8*i -: 8])), b, sh, rl);
      r[127-8*i -: 8] = v[7:0];
      nclip += v[8] ? 1 : 0;
    end
  endfunction

  function automatic logic [127:0] mk_beat(input int b);
    logic [127:0] d;
    for (int i = 0; i < 16; i++) d[127-8*i -: 8] = 8'(b * 16 + i);
    return d;
  endfunction

  // Reference model state
  logic [127:0] exp_q[$];
  int           m_in_beat = 0;
  int           m_out_beat = 0;
  int           m_tiles = 0;
  longint       m_sat = 0;
  int           m_bias = 0;
  int           m_shift = 0;
  bit           m_relu = 1'b0;
  logic [127:0] last_out = '0;

  // Mid-cycle compare, then advance the model by the handshakes the next edge will take.
  always @(negedge CLOCK) begin
    logic [127:0] r;
    int nclip;
    if (reset) begin
      exp_q.delete();
      m_in_beat = 0; m_out_beat = 0; m_tiles = 0; m_sat = 0;
    end else begin
      chk("tile_count", 128'(tile_count), 128'(m_tiles));
      chk("sat_count", 128'(sat_count), 128'(m_sat));
      if (exp_q.size() == 0) begin
        chk("out_valid with nothing pending", 128'(out_valid), 128'd0);
      end else if (out_valid) begin
        chk("out_data", out_data, exp_q[0]);
        chk("out_sop", 128'(out_sop), 128'(m_out_beat == 0));
        chk("out_eop", 128'(out_eop), 128'(m_out_beat == 15));
      end
      if (flush) begin
        exp_q.delete();
        m_in_beat = 0; m_out_beat = 0;
      end else begin
        if (out_valid && out_ready && exp_q.size() > 0) begin
          last_out = out_data;
          void'(exp_q.pop_front());
          if (m_out_beat == 15) begin m_out_beat = 0; m_tiles++; end
          else m_out_beat++;
        end
        if (in_valid && in_ready) begin
          if (m_in_beat == 0) begin
            m_bias = int'($signed(cfg_bias)); m_shift = int'(cfg_shift); m_relu = cfg_relu;
          end
          model_beat(in_data, m_bias, m_shift, m_relu, r, nclip);
          exp_q.push_back(r);
          m_sat = m_sat + nclip;
          if (m_sat > 64'hFFFF_FFFF) m_sat = 64'hFFFF_FFFF;
          m_in_beat = (m_in_beat + 1) % 16;
        end
      end
    end
  end

  task automatic send(input logic [127:0] d);
    int t;
    bit done;
    in_data = d; in_valid = 1'b1; t = 0; done = 1'b0;
    while (!done) begin
      @(negedge CLOCK);
      if (in_ready) begin
        @(posedge CLOCK); #1; done = 1'b1;
      end else if (t >= 100) begin
        chk("send timeout (in_ready)", 128'(in_ready), 128'd1); done = 1'b1;
      end else begin
        t++;
      end
    end
  endtask

  task automatic wait_drain();
    int t;
    in_valid = 1'b0; t = 0;
    while ((exp_q.size() != 0 || out_valid) && t < 300) begin
      @(posedge CLOCK); #1; t++;
    end
    chk("drain pending beats", 128'(exp_q.size()), 128'd0);
  endtask

  task automatic send_tile(input logic [127:0] d, input logic [7:0] b, input logic [2:0] sh, input logic rl);
    cfg_bias = b; cfg_shift = sh; cfg_relu = rl;
    for (int k = 0; k < 16; k++) send(d);
    wait_drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int t;
    reset = 1'b1; flush = 1'b0; cfg_bias = 8'd0; cfg_shift = 3'd0; cfg_relu = 1'b0;
    in_data = '0; in_valid = 1'b0; out_ready = 1'b1;

    // model pinned by hand-computed lanes
    chk("model 7>>2", 128'(model_lane(7, 0, 2, 0)), 128'h002);
    chk("model -7>>2", 128'(model_lane(-7, 0, 2, 0)), 128'h0FE);
    chk("model 6>>2", 128'(model_lane(6, 0, 2, 0)), 128'h002);
    chk("model -128>>2", 128'(model_lane(-128, 0, 2, 0)), 128'h0E0);
    chk("model 120+10 sat", 128'(model_lane(120, 10, 0, 0)), 128'h17F);
    chk("model relu -5", 128'(model_lane(-5, 0, 0, 1)), 128'h000);

    #1;
    chk("reset in_ready", 128'(in_ready), 128'd0);
    chk("reset out_valid", 128'(out_valid), 128'd0);
    chk("reset out_data", out_data, 128'd0);
    chk("reset counts", {64'd0, tile_count, sat_count}, 128'd0);
    repeat (3) @(posedge CLOCK);
    #1 reset = 1'b0;
    @(posedge CLOCK); #1;
    chk("in_ready after reset", 128'(in_ready), 128'd1);

    // 1: passthrough tile with exact 2-cycle latency
    send(mk_beat(0));
    in_valid = 1'b0;
    chk("latency N+1 out_valid", 128'(out_valid), 128'd0);
    @(posedge CLOCK); #1;
    chk("latency N+2 out_valid", 128'(out_valid), 128'd1);
    chk("latency N+2 out_sop", 128'(out_sop), 128'd1);
    chk("latency N+2 out_data", out_data, 128'h000102030405060708090A0B0C0D0E0F);
    for (int b = 1; b < 16; b++) send(mk_beat(b));
    wait_drain();
    chk("t1 tile_count", 128'(tile_count), 128'd1);
    chk("t1 last beat", last_out, 128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF);

    // 2: saturation both ways
    send_tile({16{8'd120}}, 8'd10, 3'd0, 1'b0);
    chk("t2 sat high", last_out, {16{8'h7F}});
    chk("t2 sat_count", 128'(sat_count), 128'd256);
    send_tile({16{8'h83}}, 8'hF6, 3'd0, 1'b0);
    chk("t2 sat low", last_out, {16{8'h80}});
    chk("t2 sat_count 2", 128'(sat_count), 128'd512);

    // 3: rounding shift and relu
    send_tile({4{32'h07F90680}}, 8'd0, 3'd2, 1'b0);
    chk("t3 shift lanes", last_out, {4{32'h02FE02E0}});
    send_tile({16{8'hFB}}, 8'd0, 3'd0, 1'b1);
    chk("t3 relu lanes", last_out, 128'd0);
    chk("t3 sat unchanged", 128'(sat_count), 128'd512);

    // 4: backpressure
    cfg_bias = 8'd0; cfg_shift = 3'd0; cfg_relu = 1'b0;
    out_ready = 1'b0; in_valid = 1'b1; in_data = mk_beat(0); acc = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge CLOCK);
      if (in_ready) acc++;
      @(posedge CLOCK); #1;
      in_data = mk_beat(acc);
      if (c == 5) chk("t4 stalled head early", out_data, mk_beat(0));
    end
    chk("t4 accepted while stalled", 128'(acc), 128'd4);
    chk("t4 in_ready stalled", 128'(in_ready), 128'd0);
    chk("t4 stalled head late", out_data, mk_beat(0));
    chk("t4 sop held", 128'(out_sop), 128'd1);
    out_ready = 1'b1;
    for (int b = 4; b < 16; b++) send(mk_beat(b));
    wait_drain();
    chk("t4 last beat", last_out, mk_beat(15));
    chk("t4 tile_count", 128'(tile_count), 128'd6);

    // 5: bias change mid-tile applies from the next tile
    cfg_bias = 8'd0;
    for (int k = 0; k < 3; k++) send({16{8'h01}});
    cfg_bias = 8'd5;
    for (int k = 3; k < 16; k++) send({16{8'h01}});
    wait_drain();
    chk("t5 mid-tile bias ignored", last_out, {16{8'h01}});
    send_tile({16{8'h01}}, 8'd5, 3'd0, 1'b0);
    chk("t5 next tile bias", last_out, {16{8'h06}});
    chk("t5 tile_count", 128'(tile_count), 128'd8);

    // 6: flush at output beat 7, then async reset mid-tile
    cfg_bias = 8'd0;
    for (int b = 0; b < 9; b++) send(mk_beat(b));
    in_valid = 1'b0;
    chk("t6 head before flush", out_data, mk_beat(7));
    flush = 1'b1;
    @(posedge CLOCK); #1;
    flush = 1'b0;
    chk("t6 out_valid after flush", 128'(out_valid), 128'd0);
    chk("t6 tile_count kept", 128'(tile_count), 128'd8);
    send(mk_beat(3));
    in_valid = 1'b0; t = 0;
    while (!out_valid && t < 20) begin @(posedge CLOCK); #1; t++; end
    chk("t6 sop after flush", 128'(out_sop), 128'd1);
    chk("t6 data after flush", out_data, mk_beat(3));
    wait_drain();
    send(mk_beat(4));
    send(mk_beat(5));
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("t6 reset in_ready", 128'(in_ready), 128'd0);
    chk("t6 reset out_valid", 128'(out_valid), 128'd0);
    chk("t6 reset sop/eop", {126'd0, out_sop, out_eop}, 128'd0);
    chk("t6 reset out_data", out_data, 128'd0);
    chk("t6 reset counts", {64'd0, tile_count, sat_count}, 128'd0);
    @(posedge CLOCK); #1;
    reset = 1'b0;
    @(posedge CLOCK); #1;
    chk("t6 in_ready after reset", 128'(in_ready), 128'd1);
    repeat (3) @(posedge CLOCK);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
